rf_write_arbiter: RTL

Shares the register file's single write port between two writeback requesters: requester 0 is the ALU/immediate path and requester 1 is the load/multi-cycle unit. Each requester pushes (rd, data) pairs through a valid/ready handshake into its own small FIFO. The block grants one entry per cycle and drives the register file's rd, rd_din and write_enable inputs. It also exports a 32-bit pending-write mask that the control unit uses for hazard stalls.

---
 rtl/rf_write_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Shares the register file's single write port between two writeback requesters.
// Requester 0 is the ALU/immediate path, requester 1 the load/multi-cycle unit.
// Each requester pushes (rd, data) pairs into its own DEPTH-entry FIFO through a
// valid/ready handshake. One head entry is granted per cycle and drives the
// register file write port. A 32-bit pending-write mask of all queued
// destinations is exported for hazard stalls.
//
// Parameters
//   DEPTH            entries per requester FIFO (power of two, 2..8)
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   req0_valid/ready/rd/data  requester 0 push handshake and payload
//   req1_valid/ready/rd/data  requester 1 push handshake and payload
//   wb_rd            register file rd
//   wb_din           register file rd_din
//   wb_write_enable  register file write_enable (0 for rd == x0)
//   pending_mask     bit r set while a queued, uncommitted write targets xr
//
// Configuration
//   RF_ARB_STRICT_PRIO_EN  when defined, requester 1 always wins when both heads
//                          are valid and the round-robin pointer stays at 0.
//                          Undefined (default): round-robin arbitration.

module rf_write_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_rd,
   input  logic [31:0] req0_data,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_rd,
   input  logic [31:0] req1_data,

   output logic [4:0]  wb_rd,
   output logic [31:0] wb_din,
   output logic        wb_write_enable,
   output logic [31:0] pending_mask
);

   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned Slots = 2 * DEPTH;

   // Requester-indexed views of the two push ports
   logic [1:0]  in_valid;
   logic [4:0]  in_rd   [2];
   logic [31:0] in_data [2];

   assign in_valid   = {req1_valid, req0_valid};
   assign in_rd[0]   = req0_rd;
   assign in_rd[1]   = req1_rd;
   assign in_data[0] = req0_data;
   assign in_data[1] = req1_data;

   logic [1:0]  ready;
   logic [1:0]  push;
   logic [1:0]  pop;
   logic [1:0]  nonempty;
   logic [4:0]  head_rd   [2];
   logic [31:0] head_data [2];

   // slot_hit[b][k] = slot k (flattened over both FIFOs) holds a live entry for xb
   logic [31:0][Slots-1:0] slot_hit;

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   //----------------------------------------------------------------------------
   // Per-requester FIFOs
   //----------------------------------------------------------------------------
   for (genvar g = 0; g < 2; g++) begin : g_req
      logic [4:0]      rd_q   [DEPTH];
      logic [4:0]      rd_d   [DEPTH];
      logic [31:0]     data_q [DEPTH];
      logic [31:0]     data_d [DEPTH];
      logic [PtrW-1:0] rptr_q, rptr_d;
      logic [PtrW-1:0] wptr_q, wptr_d;
      logic [CntW-1:0] cnt_q, cnt_d;
      logic            full;

      assign full         = (cnt_q == CntW'(DEPTH));
      assign nonempty[g]  = (cnt_q != '0);
      // No bypass: a full FIFO refuses even when its head pops this cycle
      assign ready[g]     = ~full & ~reset;
      assign push[g]      = in_valid[g] & ready[g];
      assign head_rd[g]   = rd_q[rptr_q];
      assign head_data[g] = data_q[rptr_q];

      always_comb begin
         rd_d   = rd_q;
         data_d = data_q;
         wptr_d = wptr_q;
         rptr_d = rptr_q;
         if (push[g]) begin
            rd_d[wptr_q]   = in_rd[g];
            data_d[wptr_q] = in_data[g];
            // DEPTH is a power of two, so natural overflow wraps modulo DEPTH
            wptr_d         = wptr_q + PtrW'(1);
         end
         if (pop[g]) begin
            rptr_d = rptr_q + PtrW'(1);
         end
         cnt_d = cnt_q + CntW'(push[g]) - CntW'(pop[g]);
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
         end
      end

      // Payload storage needs no reset; liveness comes from the pointers/count
      always_ff @(posedge clk) begin
         rd_q   <= rd_d;
         data_q <= data_d;
      end

      for (genvar s = 0; s < DEPTH; s++) begin : g_slot
         logic [PtrW-1:0] offset;
         logic            live;

         // Slot s is live when its distance from the read pointer is below count
         assign offset = PtrW'(s) - rptr_q;
         assign live   = ({1'b0, offset} < cnt_q);

         for (genvar b = 0; b < 32; b++) begin : g_bit
            assign slot_hit[b][g*DEPTH+s] = live && (rd_q[s] == 5'(b));
         end
      end
   end

   //----------------------------------------------------------------------------
   // Grant and round-robin pointer
   //----------------------------------------------------------------------------
   logic prio_q, prio_d;
   logic grant_valid;
   logic grant_sel;

   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = 1'b0;
      pop         = 2'b00;
      prio_d      = prio_q;
      // Reset suppresses the grant so queued entries are never written
      if (!reset) begin
         case (nonempty)
            2'b01: begin
               grant_valid = 1'b1;
               grant_sel   = 1'b0;
            end
            2'b10: begin
               grant_valid = 1'b1;
               grant_sel   = 1'b1;
            end
            2'b11: begin
               grant_valid = 1'b1;
`ifdef RF_ARB_STRICT_PRIO_EN
               grant_sel   = 1'b1;
`else
               grant_sel   = prio_q;
`endif
            end
            default: begin
               grant_valid = 1'b0;
            end
         endcase
      end
      if (grant_valid) begin
         pop[grant_sel] = 1'b1;
`ifndef RF_ARB_STRICT_PRIO_EN
         // Point at the loser for the next contested cycle
         prio_d = ~grant_sel;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

   //----------------------------------------------------------------------------
   // Register file write port and pending mask
   //----------------------------------------------------------------------------
   always_comb begin
      wb_rd           = 5'd0;
      wb_din          = 32'd0;
      wb_write_enable = 1'b0;
      if (grant_valid) begin
         wb_rd           = head_rd[grant_sel];
         wb_din          = head_data[grant_sel];
         // x0 entries are still popped but never written
         wb_write_enable = (head_rd[grant_sel] != 5'd0);
      end
   end

   logic [31:0] mask_raw;

   for (genvar b = 0; b < 32; b++) begin : g_mask
      assign mask_raw[b] = |slot_hit[b];
   end

   assign pending_mask = reset ? 32'd0 : (mask_raw & ~32'd1);

endmodule
